// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master transaction engine among NUM_REQ clients.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES clocks.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_LEN       = 7,
    parameter int DATA_LEN       = 8,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata1,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata2,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_err,
    output logic [DATA_LEN-1:0]          rsp_rdata1,
    output logic [DATA_LEN-1:0]          rsp_rdata2,
    output logic                         m_start,
    output logic                         m_rw,
    output logic [ADDR_LEN-1:0]          m_addr,
    output logic [DATA_LEN-1:0]          m_wdata1,
    output logic [DATA_LEN-1:0]          m_wdata2,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic                         m_nack,
    input  logic [DATA_LEN-1:0]          m_rdata1,
    input  logic [DATA_LEN-1:0]          m_rdata2
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (NUM_REQ < 2 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_txn_arbiter: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;

    state_t         state;
    state_t         state_n;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  pick_idx;
    logic           pick_found;
    logic [RW-1:0]  retry_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           retry_ok;
    logic           gap_last;
    logic           to_hit;

    assign retry_ok = int'(retry_cnt) < MAX_RETRY;
    assign gap_last = gap_cnt == GW'(GAP_CYCLES - 1);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Cleared everywhere outside WAIT so each WAIT entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != WAIT)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = to_cnt == TW'(TIMEOUT_CYCLES);
`else
    assign to_hit = 1'b0;
`endif

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (pick_found) state_n = ISSUE;
            ISSUE: if (!m_busy) state_n = WAIT;
            WAIT: begin
                if (m_done)
                    state_n = (m_nack && retry_ok) ? GAP : RESP;
                else if (to_hit)
                    state_n = RESP;
            end
            GAP:   if (gap_last) state_n = ISSUE;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        m_start   = 1'b0;
        rsp_valid = '0;
        unique case (state)
            ISSUE:   m_start = !m_busy;
            RESP:    rsp_valid = grant;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            owner      <= '0;
            grant      <= '0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
            m_rw       <= 1'b0;
            m_addr     <= '0;
            m_wdata1   <= '0;
            m_wdata2   <= '0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        grant     <= NUM_REQ'(1) << pick_idx;
                        retry_cnt <= '0;
                        m_rw      <= req_rw[pick_idx];
                        m_addr    <= req_addr[pick_idx*ADDR_LEN +: ADDR_LEN];
                        m_wdata1  <= req_wdata1[pick_idx*DATA_LEN +: DATA_LEN];
                        m_wdata2  <= req_wdata2[pick_idx*DATA_LEN +: DATA_LEN];
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        if (m_nack && retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            rsp_err    <= m_nack;
                            rsp_rdata1 <= m_rdata1;
                            rsp_rdata2 <= m_rdata2;
                        end
                    end else if (to_hit) begin
                        rsp_err    <= 1'b1;
                        rsp_rdata1 <= '0;
                        rsp_rdata2 <= '0;
                    end
                end
                RESP: begin
                    grant  <= '0;
                    rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin scheduler that shares one I2C master transaction engine (address + two data bytes, read or write) between NUM_REQ client requesters. It latches the winning request's payload, fires the engine, waits for completion, retries address/data NACKs up to MAX_RETRY times with a fixed bus-idle gap, and returns read data and status to the granted client. It sits between client logic and the master FSM that drives scl/sda toward slaves such as the 7-bit-address two-byte slave at 7'b1011011.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_LEN, 7, slave address width
- DATA_LEN, 8, data byte width
- MAX_RETRY, 2, re-issues after NACK (0 = no retry)
- GAP_CYCLES, 16, idle clk cycles between NACK and re-issue (≥1)
- TIMEOUT_CYCLES, 4096, WAIT watchdog limit (used only with I2C_ARB_TIMEOUT_EN)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-client request level; held until that client's rsp_valid
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_addr  in  NUM_REQ*ADDR_LEN  packed, client i at [i*ADDR_LEN +: ADDR_LEN]
- req_wdata1, req_wdata2  in  NUM_REQ*DATA_LEN  packed write bytes
- grant  out  NUM_REQ  one-hot owner of current transaction, 0 when idle
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to owner
- rsp_err  out  1  qualified by rsp_valid: final attempt NACKed or timed out
- rsp_rdata1, rsp_rdata2  out  DATA_LEN  qualified by rsp_valid, read bytes
- m_start  out  1  one-cycle engine launch pulse
- m_rw  out  1, m_addr  out  ADDR_LEN, m_wdata1/m_wdata2  out  DATA_LEN  latched payload, stable from grant through RESP
- m_busy  in  1  engine occupied / bus not free
- m_done  in  1  one-cycle completion pulse
- m_nack  in  1  qualified by m_done
- m_rdata1, m_rdata2  in  DATA_LEN  qualified by m_done

## Operation
- States: IDLE, ISSUE, WAIT, GAP, RESP.
- IDLE: if |req, pick first set bit searching upward from rr_ptr (wrapping); register grant, payload; clear retry_cnt; -> ISSUE.
- ISSUE: m_start = 1 combinationally when !m_busy; on that edge -> WAIT. m_busy high holds ISSUE indefinitely.
- WAIT: on m_done: if m_nack && retry_cnt < MAX_RETRY -> GAP, retry_cnt+1; else latch m_rdata1/2 and m_nack -> RESP. m_done outside WAIT ignored.
- GAP: count GAP_CYCLES clocks, -> ISSUE (same payload).
- RESP: rsp_valid[owner]=1 one cycle, rsp_err driven; rr_ptr = owner+1 mod NUM_REQ; grant cleared; -> IDLE.
- Client dropping req after grant: transaction still completes, rsp_valid still pulses. Payload changes after grant ignored.
- Write transactions return rsp_rdata1/2 = whatever engine reports; clients ignore.
- retry_cnt width clog2(MAX_RETRY+1); GAP counter width clog2(GAP_CYCLES+1).

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, m_start 0, m_rw/m_addr/m_wdata 0, counters 0.
- req seen at edge E0 → grant valid after E0; m_start high in cycle E0..E1 if m_busy low.
- Zero-retry, ideal engine: m_done at edge Ed → rsp_valid high cycle Ed..Ed+1; next grant earliest after Ed+2 (one IDLE cycle).
- Each retry adds GAP_CYCLES + 1 cycles before the next m_start.
- Reset mid-transaction: immediate return to reset values; no rsp_valid issued; engine must be reset in parallel.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: WAIT counter increments each cycle; reaching TIMEOUT_CYCLES without m_done -> RESP with rsp_err=1, rsp_rdata 0, no retry; counter cleared on entering WAIT.
- Undefined: no counter; WAIT waits for m_done forever.

## Test plan
- Client 1 read addr 7'h5B, engine m_done m_nack=0 rdata 8'hA5/8'h3C → grant=4'b0010, one m_start, rsp_valid=4'b0010, rsp_err=0, rdata A5/3C.
- req=4'b1111 held continuously, ideal engine → grants in order 0,1,2,3,0, each rsp_valid once.
- Engine NACKs every attempt, MAX_RETRY=2 → exactly 3 m_start pulses spaced ≥GAP_CYCLES+1, rsp_err=1.
- NACK once then ACK → 2 m_start pulses, rsp_err=0.
- m_busy held high 50 cycles after grant → m_start stays 0, fires in first cycle m_busy low; rst asserted during WAIT → grant=0, no rsp_valid.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, no m_done → rsp_valid 64–65 cycles after entering WAIT, rsp_err=1.
